// File: rtl/mul_feeder_if.sv
`default_nettype none
// ============================================================================
// mul_feeder_if : upstream operand, multiplier-side and result signals of
//                 mul_feeder.  Revision: 1.0
// ============================================================================
interface mul_feeder_if #(
   parameter int A_W = 8,
   parameter int B_W = 8,
   parameter int P_W = 17
);
   logic           in_valid;
   logic [A_W-1:0] in_a;
   logic [B_W-1:0] in_b;
   logic           in_ready;
   logic [A_W-1:0] mul_a;
   logic [B_W-1:0] mul_b;
   logic           mul_start;
   logic [P_W-1:0] mul_o;
   logic           mul_fin;
   logic [P_W-1:0] res;
   logic           res_valid;
   logic           err;
   logic           busy;
   logic [7:0]     done_cnt;

   modport slave (
      input  in_valid, in_a, in_b, mul_o, mul_fin,
      output in_ready, mul_a, mul_b, mul_start, res, res_valid, err, busy, done_cnt
   );

   modport master (
      output in_valid, in_a, in_b, mul_o, mul_fin,
      input  in_ready, mul_a, mul_b, mul_start, res, res_valid, err, busy, done_cnt
   );
endinterface
`default_nettype wire

// File: rtl/mul_feeder.sv
`default_nettype none
// ============================================================================
// mul_feeder : operand FIFO, issue/capture FSM and watchdog around a
//              sequential multiplier.  Revision: 1.0
// ============================================================================
module mul_feeder #(
   parameter int A_W     = 8,
   parameter int B_W     = 8,
   parameter int P_W     = 17,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  wire logic   ck,
   input  wire logic   rst,
   mul_feeder_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int PAIR_W = A_W + B_W;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   logic [PAIR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              in_ready_w;
   logic              push_w;
   logic              pop_w;
   logic [PAIR_W-1:0] head_w;

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [A_W-1:0]    mul_a_q;
   logic [B_W-1:0]    mul_b_q;
   logic              mul_start_q;
   logic [P_W-1:0]    res_q;
   logic              res_valid_q;
   logic              err_q;
   logic [7:0]        done_cnt_q;

   assign in_ready_w = (count_q != CNT_W'(DEPTH));
   assign push_w     = bus.in_valid & in_ready_w;
   // Pop decision uses the registered count, so a pair pushed into an empty
   // FIFO only becomes visible to the issue logic one edge later.
   assign pop_w      = (state_q == S_IDLE) && (count_q != '0);
   assign head_w     = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_w) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
   end

   always_ff @(posedge ck) begin
      if (push_w) begin
         mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         done_cnt_q  <= '0;
      end else begin
         mul_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop_w) begin
                  mul_a_q     <= head_w[PAIR_W-1:B_W];
                  mul_b_q     <= head_w[B_W-1:0];
                  mul_start_q <= 1'b1;
                  timer_q     <= '0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // fin takes priority over a coinciding timeout
               if (bus.mul_fin) begin
                  res_q       <= bus.mul_o;
                  res_valid_q <= 1'b1;
                  done_cnt_q  <= done_cnt_q + 8'd1;
                  state_q     <= S_IDLE;
               end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_start = mul_start_q;
   assign bus.res       = res_q;
   assign bus.res_valid = res_valid_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q == S_WAIT);
   assign bus.done_cnt  = done_cnt_q;
endmodule
`default_nettype wire

// File: doc/mul_feeder.md
Name: mul_feeder

Overview:
- Operand-issue and result-capture stage wrapped around the sequential multiplier `mul` (ports A, B, O, ck, start, fin).
- Buffers operand pairs from an upstream valid/ready source in a small FIFO.
- Issues each pair to `mul` with a one-cycle start pulse, holds the operands stable until fin, and captures O as a registered result pulse.
- Adds a completion counter and a watchdog timeout so a hung multiplier cannot stall the pipeline.

Parameters:
A_W, 8, width of operand A
B_W, 8, width of operand B
P_W, 17, width of product O returned by mul
DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
ck  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream operand pair valid
in_a  in  A_W  operand A
in_b  in  B_W  operand B
in_ready  out  1  FIFO not full; push occurs when in_valid & in_ready at posedge
mul_a  out  A_W  to mul A, registered
mul_b  out  B_W  to mul B, registered
mul_start  out  1  to mul start, registered one-cycle pulse
mul_o  in  P_W  from mul O
mul_fin  in  1  from mul fin
res  out  P_W  captured product
res_valid  out  1  one-cycle pulse, res valid
err  out  1  one-cycle pulse on timeout abort
busy  out  1  high while state != IDLE
done_cnt  out  8  completed multiplies, wraps 255 -> 0

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied (rd/wr pointers and count = 0); state=IDLE.
  - Outputs after reset: mul_a=0, mul_b=0, mul_start=0, res=0, res_valid=0, err=0, done_cnt=0.
  - busy=0; in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards queued and in-flight pairs; a later mul_fin is ignored because the block is in IDLE.
- FIFO:
  - in_ready = (count != DEPTH), combinational from count.
  - Push: in_valid & in_ready at posedge writes {in_a, in_b}. Pointers wrap modulo DEPTH.
  - Pop happens only from IDLE. Pop and push in the same cycle: count unchanged, both pointers advance.
  - A pair pushed into an empty FIFO is not popped at the same edge; it is popped at the next edge.
- FSM states: IDLE, WAIT.
  - IDLE & count!=0 at posedge: mul_a/mul_b <= head pair, pop, mul_start <= 1, timer <= 0, state <= WAIT.
  - IDLE & count==0: hold.
  - mul_start is high for exactly one cycle; it is cleared at the next posedge unconditionally.
  - WAIT & mul_fin: res <= mul_o, res_valid <= 1, done_cnt <= done_cnt+1, state <= IDLE.
  - WAIT & !mul_fin & timer==TIMEOUT-1: err <= 1, state <= IDLE; res and done_cnt unchanged.
  - WAIT otherwise: timer <= timer+1.
  - mul_fin is accepted in any WAIT cycle, including the cycle where mul_start is high. If mul_fin and the timeout coincide, fin wins.
- mul_a/mul_b hold from issue until the next issue; they never change while in WAIT.
- mul_fin in IDLE is ignored.
- res_valid and err are cleared at the next posedge.
- Minimum spacing between starts: IDLE is re-entered after fin, so the next mul_start is 1 cycle after res_valid.
- Latency:
  - Push at edge E0 into an empty idle block -> mul_start high in the cycle after E1.
  - res_valid rises at the edge after the first sampled mul_fin.
- busy = (state==WAIT).

Test Plan:
- Reset, then push A=8'h03 B=8'h05; model mul returns fin after 9 cycles with O=17'h0000F -> mul_start high exactly 1 cycle with mul_a=03 mul_b=05, res=0000F with res_valid 1 cycle, done_cnt=1.
- Push 6 pairs back-to-back with DEPTH=4 while mul is slow -> in_ready drops after 4 queued, pairs are issued in order, no pair is lost or duplicated, done_cnt=6.
- Random A/B for 200 ops against a behavioural mul (fin latency 1..20 cycles) -> each res equals A*B zero-extended to 17 bits; mul_a/mul_b are stable throughout every WAIT.
- Model mul never asserts fin, TIMEOUT=64 -> err pulses exactly 64 cycles after mul_start, block returns to IDLE, next pair is issued, done_cnt unchanged.
- Assert rst 3 cycles into WAIT with 2 pairs queued, then assert mul_fin -> no res_valid, in_ready=1, count=0, done_cnt=0, mul_start stays 0.
- Perform 256 completions -> done_cnt wraps to 0. Stray mul_fin while IDLE -> no res_valid.
